// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared definitions for the SPI flash read arbiter:
//   ADDR_W  - flash byte-address width
//   TAG_W   - word tag width (byte address without the two word-offset bits)
//   state_e - arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
package spi_flash_pkg;

  localparam int ADDR_W = 24;
  localparam int TAG_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_flash_hit_buffer.sv
// spi_flash_hit_buffer
// Single-entry "last word" buffer for one requester port.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   lookup_tag         - word tag of the port's current request
//   hit                - buffer valid and its tag matches lookup_tag
//   rd_data            - buffered word (meaningful only with hit)
//   fill_en            - load fill_tag/fill_data and mark the entry valid
//   fill_tag/fill_data - word tag and word returned by the flash
//   flush              - invalidate the entry; wins over a coincident fill
module spi_flash_hit_buffer #(
  parameter int TAG_W = spi_flash_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             flush
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end
    // Tag and data may still load, but the entry stays unusable.
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit     = valid_q && (tag_q == lookup_tag);
  assign rd_data = data_q;

endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
// Arbitrates word reads from two requester ports onto one SPI flash
// controller, with an optional single-word hit buffer per port.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid[1:0]      - per-port request, held with req_addr until rsp_valid
//   req_addr[1:0]       - per-port byte address (bits [1:0] ignored)
//   rsp_valid[1:0]      - per-port one-cycle response pulse
//   rsp_data            - response word, shared, qualified by rsp_valid
//   flush               - one-cycle pulse invalidating both hit buffers
//   flash_addr          - word-aligned address to the flash controller
//   flash_strobe        - one-cycle start pulse to the flash controller
//   flash_data          - word from the flash controller
//   flash_done          - one-cycle pulse, flash_data valid
//   flash_initialized   - flash controller ready for reads
//   dbg_state           - current FSM state (spi_flash_pkg::state_e)
// Handshake: a port raises req_valid and holds it with a stable req_addr
// until it sees its rsp_valid pulse; exactly one rsp_valid pulse answers
// each accepted request, and only one flash access is ever in flight.
module spi_flash_arbiter #(
  parameter int HIT_BUF_EN = 1,
  parameter int ADDR_W     = spi_flash_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             rsp_valid,
  output logic [31:0]            rsp_data,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      flash_addr,
  output logic                   flash_strobe,
  input  logic [31:0]            flash_data,
  input  logic                   flash_done,
  input  logic                   flash_initialized,
  output logic [1:0]             dbg_state
);

  import spi_flash_pkg::*;

  localparam int TW = ADDR_W - 2;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
  logic              flash_strobe_q, flash_strobe_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic [1:0]        eligible;
  logic              sel;
  logic              fill_go;
  logic [1:0]        fill_en;
  logic [1:0]        hit_raw;
  logic [1:0]        buf_hit;
  logic [31:0]       buf_data [2];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[0][1:0], req_addr[1][1:0]};

  // Buffer fill happens on the flash capture, into the granted port only.
  assign fill_go = (HIT_BUF_EN != 0) && (state_q == WAIT) && flash_done;

  for (genvar p = 0; p < 2; p++) begin : g_buf
    assign fill_en[p] = fill_go && (gnt_q == 1'(p));
    assign buf_hit[p] = (HIT_BUF_EN != 0) && hit_raw[p];

    spi_flash_hit_buffer #(
      .TAG_W (TW)
    ) u_hit_buffer (
      .clk        (clk),
      .reset      (reset),
      .lookup_tag (req_addr[p][ADDR_W-1:2]),
      .hit        (hit_raw[p]),
      .rd_data    (buf_data[p]),
      .fill_en    (fill_en[p]),
      .fill_tag   (flash_addr_q[ADDR_W-1:2]),
      .fill_data  (flash_data),
      .flush      (flush)
    );
  end

  // A port whose response is pulsing this cycle is still holding req_valid
  // (the requester only reacts at the edge), so it must not be re-selected.
  assign eligible = req_valid & ~rsp_valid_q;

  // Port 1 wins if it requests alone, or if both request and port 0 was
  // the last one granted.
  assign sel = eligible[1] & (~eligible[0] | ~last_grant_q);

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_grant_d   = last_grant_q;
    flash_addr_d   = flash_addr_q;
    flash_strobe_d = 1'b0;
    word_d         = word_q;
    rsp_valid_d    = 2'b00;
    rsp_data_d     = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (flash_initialized && (eligible != 2'b00)) begin
          gnt_d = sel;
          if (buf_hit[sel]) begin
            // Word is latched now, so a flush in this cycle cannot lose it.
            word_d  = buf_data[sel];
            state_d = RESP;
          end else begin
            flash_addr_d   = {req_addr[sel][ADDR_W-1:2], 2'b00};
            flash_strobe_d = 1'b1;
            state_d        = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (flash_done) begin
          word_d  = flash_data;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d[gnt_q] = 1'b1;
        rsp_data_d         = word_q;
        last_grant_d       = gnt_q;
        state_d            = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      last_grant_q   <= 1'b1;
      flash_addr_q   <= '0;
      flash_strobe_q <= 1'b0;
      word_q         <= '0;
      rsp_valid_q    <= 2'b00;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      last_grant_q   <= last_grant_d;
      flash_addr_q   <= flash_addr_d;
      flash_strobe_q <= flash_strobe_d;
      word_q         <= word_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign flash_addr   = flash_addr_q;
  assign flash_strobe = flash_strobe_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter
// Directed bench for spi_flash_arbiter with a flash controller model,
// a per-cycle protocol/data monitor and literal latency/hit expectations.
module tb_spi_flash_arbiter;

  localparam int AW = 24;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0]          rsp_valid;
  logic [31:0]         rsp_data;
  logic                flush;
  logic [AW-1:0]       flash_addr;
  logic                flash_strobe;
  logic [31:0]         flash_data;
  logic                flash_done;
  logic                flash_initialized;
  logic [1:0]          dbg_state;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .HIT_BUF_EN (1),
    .ADDR_W     (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .flush             (flush),
    .flash_addr        (flash_addr),
    .flash_strobe      (flash_strobe),
    .flash_data        (flash_data),
    .flash_done        (flash_done),
    .flash_initialized (flash_initialized),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  int          rsp_cnt = 0;
  logic [AW-1:0] strobe_addr = '0;
  bit          strobe_pending = 0;
  bit          fl_busy = 0;
  int          grant_log[$];
  int          mon_p;
  int          flash_delay = 2;
  bit          rand_delay = 0;
  bit          flush_on_done = 0;
  int          drv_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash content: every word is a fixed function of its aligned address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    w = {a[AW-1:2], 2'b00};
    if (w == 24'h000100) return 32'hDEADBEEF;
    return {8'hC3, w} ^ 32'h0000_5A5A;
  endfunction

  // ---------------- flash controller model ----------------
  initial begin
    int cnt;
    bit fod_active;
    cnt = 0;
    fod_active = 0;
    flash_done = 1'b0;
    flash_data = '0;
    forever begin
      @(posedge clk); #1;
      flash_done = 1'b0;
      if (fod_active) begin
        flush = 1'b0;
        fod_active = 0;
      end
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            flash_done = 1'b1;
            flash_data = mem_word(flash_addr);
            if (flush_on_done) begin
              flush = 1'b1;
              fod_active = 1;
            end
          end
        end
        if (flash_strobe) cnt = rand_delay ? int'($urandom_range(1, 5)) : flash_delay;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      fl_busy = 0;
      strobe_pending = 0;
    end else begin
      if (flash_strobe) begin
        check("strobe_vs_done", 32'(flash_done), 32'd0);
        check("one_outstanding", 32'(fl_busy), 32'd0);
        fl_busy = 1;
        strobe_cnt++;
        strobe_addr = flash_addr;
        strobe_pending = 1;
      end
      if (flash_done) fl_busy = 0;
      if (rsp_valid != 2'b00) begin
        check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
        mon_p = rsp_valid[1] ? 1 : 0;
        check("rsp_has_req", 32'(req_valid[mon_p]), 32'd1);
        check("rsp_data", rsp_data, mem_word(req_addr[mon_p]));
        if (strobe_pending)
          check("miss_addr", 32'(strobe_addr), 32'({req_addr[mon_p][AW-1:2], 2'b00}));
        strobe_pending = 0;
        rsp_cnt++;
        grant_log.push_back(mon_p);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input int p, input logic [AW-1:0] a);
    @(posedge clk); #1;
    req_valid[p] = 1'b1;
    req_addr[p]  = a;
  endtask

  // lat counts falling edges from the request's first cycle to the response
  // cycle inclusive: a hit answers on the 3rd, a miss on the (delay+4)th.
  task automatic wait_rsp(input int p, output int lat, output logic [31:0] word);
    lat = 0;
    word = '0;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid[p]) begin
        word = rsp_data;
        break;
      end
      if (lat >= 300) begin
        checks++;
        failures++;
        $display("FAIL rsp_timeout: port %0d got no response within %0d cycles", p, lat);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic do_req(input int p, input logic [AW-1:0] a, input bit with_flush,
                        output int lat, output int ns, output logic [31:0] word);
    int s0;
    s0 = strobe_cnt;
    start_req(p, a);
    if (with_flush) begin
      flush = 1'b1;
      fork
        begin
          @(posedge clk); #1;
          flush = 1'b0;
        end
      join_none
    end
    wait_rsp(p, lat, word);
    ns = strobe_cnt - s0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic random_driver(input int p);
    logic [AW-1:0] tbl [6];
    int lat, ns;
    logic [31:0] w;
    tbl = '{24'h000010, 24'h000020, 24'h000040, 24'h000100, 24'h000444, 24'hABCDE0};
    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(p, tbl[$urandom_range(0, 5)] | AW'($urandom_range(0, 3)), 0, lat, ns, w);
    end
    drv_done++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, ns, s0, r0, lat0, lat1, ns0, ns1, wait_cnt;
    logic [31:0] word, w0, w1;
    int exp_order[$];

    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    flush = 1'b0;
    flash_initialized = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_flash_strobe", 32'(flash_strobe), 32'd0);
    check("rst_flash_addr", 32'(flash_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(spi_flash_pkg::IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Flash not initialized: request stays pending, no strobe.
    flash_delay = 2;
    s0 = strobe_cnt;
    start_req(0, 24'h000100);
    repeat (8) @(negedge clk);
    check("init_gate_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    @(posedge clk); #1;
    flash_initialized = 1'b1;
    wait_rsp(0, lat, word);
    check("init_strobe_count", 32'(strobe_cnt - s0), 32'd1);
    check("init_flash_addr", 32'(strobe_addr), 32'h000100);
    check("init_latency", 32'(lat), 32'd6);

    // Unaligned miss then aligned hit on port 0.
    pulse_flush();
    flash_delay = 3;
    do_req(0, 24'h000103, 0, lat, ns, word);
    check("miss_strobes", 32'(ns), 32'd1);
    check("miss_flash_addr", 32'(strobe_addr), 32'h000100);
    check("miss_word", word, 32'hDEADBEEF);
    check("miss_latency", 32'(lat), 32'd7);
    do_req(0, 24'h000100, 0, lat, ns, word);
    check("hit_strobes", 32'(ns), 32'd0);
    check("hit_word", word, 32'hDEADBEEF);
    check("hit_latency", 32'(lat), 32'd3);

    // Flush behaviour and port isolation on port 1.
    flash_delay = 2;
    do_req(1, 24'h000040, 0, lat, ns, word);
    check("p1_first_miss", 32'(ns), 32'd1);
    do_req(1, 24'h000040, 0, lat, ns, word);
    check("p1_hit", 32'(ns), 32'd0);
    pulse_flush();
    do_req(1, 24'h000040, 0, lat, ns, word);
    check("flush_forces_miss", 32'(ns), 32'd1);
    do_req(0, 24'h000040, 0, lat, ns, word);
    check("port_isolation", 32'(ns), 32'd1);
    flush_on_done = 1;
    do_req(1, 24'h000044, 0, lat, ns, word);
    flush_on_done = 0;
    check("flush_at_done_strobes", 32'(ns), 32'd1);
    check("flush_at_done_word", word, 32'hC3005A1E);
    check("flush_at_done_latency", 32'(lat), 32'd6);
    do_req(1, 24'h000044, 0, lat, ns, word);
    check("flush_at_done_no_fill", 32'(ns), 32'd1);
    do_req(1, 24'h000044, 1, lat, ns, word);
    check("flush_on_hit_select_strobes", 32'(ns), 32'd0);
    check("flush_on_hit_select_word", word, 32'hC3005A1E);
    check("flush_on_hit_select_latency", 32'(lat), 32'd3);
    do_req(1, 24'h000044, 0, lat, ns, word);
    check("after_hit_flush_miss", 32'(ns), 32'd1);

    // Reset while the flash access is outstanding.
    flash_delay = 20;
    s0 = strobe_cnt;
    start_req(0, 24'h000200);
    wait_cnt = 0;
    while (strobe_cnt == s0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("reset_test_strobe_seen", 32'(strobe_cnt - s0), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_flash_strobe", 32'(flash_strobe), 32'd0);
    check("midrst_flash_addr", 32'(flash_addr), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(spi_flash_pkg::IDLE));
    r0 = rsp_cnt;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    flash_delay = 2;
    repeat (30) @(negedge clk);
    check("no_rsp_after_reset", 32'(rsp_cnt - r0), 32'd0);

    // Simultaneous requests: port 0 first after reset, then alternating.
    grant_log.delete();
    exp_order.delete();
    for (int i = 0; i < 5; i++) begin
      s0 = strobe_cnt;
      fork
        do_req(0, 24'h000010, 0, lat0, ns0, w0);
        do_req(1, 24'h000020, 0, lat1, ns1, w1);
      join
      check("pair_strobes", 32'(strobe_cnt - s0), (i == 0) ? 32'd2 : 32'd0);
      exp_order.push_back(0);
      exp_order.push_back(1);
    end
    do_req(0, 24'h000010, 0, lat, ns, word);
    exp_order.push_back(0);
    fork
      do_req(0, 24'h000010, 0, lat0, ns0, w0);
      do_req(1, 24'h000020, 0, lat1, ns1, w1);
    join
    exp_order.push_back(1);
    exp_order.push_back(0);
    check("grant_log_len", 32'(grant_log.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      check("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));

    // Random two-port traffic with random flash delay and random flushes.
    rand_delay = 1;
    drv_done = 0;
    fork
      random_driver(0);
      random_driver(1);
      begin
        while (drv_done < 2) begin
          repeat ($urandom_range(5, 20)) @(posedge clk);
          if (drv_done < 2) pulse_flush();
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
